// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg
//   Shared definitions for the RV32M divide sequencer.
//   - funct3/funct7 codes of the divide group (DIV, DIVU, REM, REMU)
//   - op encodings as seen on op_i (funct3[1:0])
//   - 2-bit FSM state encodings
//   - writeback enable levels and the hard-wired zero register address
package ex_div_ctrl_pkg;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // op[0] clear means the signed flavour (DIV, REM)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_div_ctrl_div_core_step.sv
// div_core_step
//   One combinational step of a radix-2 restoring division.
//   Ports:
//     rem_i          partial remainder from the previous step
//     dividend_bit_i next dividend bit to shift in (MSB first)
//     divisor_i      divisor magnitude
//     rem_o          partial remainder after this step
//     q_bit_o        quotient bit produced by this step
module div_core_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  dividend_bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_bit_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  // The shifted remainder keeps one extra bit so a remainder with its MSB set
  // (possible for large unsigned divisors) is not lost; the borrow out of the
  // DW+1-bit subtract doubles as the compare result.
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[DATA_WIDTH];
    rem_o   = q_bit_o ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl
//   Multi-cycle sequencer for DIV/DIVU/REM/REMU in EX. Stalls the pipeline
//   while a restoring division runs, then issues a one-cycle writeback.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start_i        request pulse, sampled only in IDLE
//     op_i           funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//     dividend_i     rs1 value
//     divisor_i      rs2 value
//     reg_waddr_i    destination rd
//     flush_i        cancels any operation in flight
//     busy_o         stall request, high in CALC and FIX
//     ready_o        one-cycle result-valid pulse
//     result_o       quotient or remainder, zero when not ready
//     reg_we_o       register write enable, mirrors ready_o
//     reg_waddr_o    latched rd while ready_o, else 0
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [1:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  dividend_i,
  input  logic [DATA_WIDTH-1:0]  divisor_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   ready_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o
);

  localparam int                    CW         = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST_COUNT = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]  dividend_q, divisor_q, quot_q, rem_q, result_q;
  logic [CW-1:0]          count_q;
  logic [1:0]             op_q;
  logic [RADDR_WIDTH-1:0] rd_q;
  logic                   signs_differ_q, dividend_neg_q;

  logic                  in_signed, div_by_zero, overflow;
  logic [DATA_WIDTH-1:0] dividend_abs, divisor_abs;
  logic [CW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] rem_step;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] quot_fix, rem_fix;

  // Request decode: operand magnitudes and the two cases that bypass the
  // iterative loop. Overflow is only meaningful for the signed ops.
  always_comb begin
    in_signed    = op_is_signed(op_i);
    dividend_abs = (in_signed && dividend_i[DATA_WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
    divisor_abs  = (in_signed && divisor_i[DATA_WIDTH-1])  ? (~divisor_i + 1'b1)  : divisor_i;
    div_by_zero  = (divisor_i == '0);
    overflow     = in_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
  end

  // Dividend bits are consumed MSB first as the step counter advances.
  assign bit_idx = LAST_COUNT - count_q;

  div_core_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (dividend_q[bit_idx]),
    .divisor_i      (divisor_q),
    .rem_o          (rem_step),
    .q_bit_o        (q_bit)
  );

  // Sign restoration: quotient is negative when operand signs differ, the
  // remainder follows the dividend. Unsigned ops pass through untouched.
  always_comb begin
    quot_fix = (op_is_signed(op_q) && signs_differ_q) ? (~quot_q + 1'b1) : quot_q;
    rem_fix  = (op_is_signed(op_q) && dividend_neg_q) ? (~rem_q + 1'b1)  : rem_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Outputs depend only on state (and on
  // flush_i in DONE, which must kill the writeback in that same cycle).
  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b0;
    ready_o     = 1'b0;
    reg_we_o    = WRITE_DISABLE;
    result_o    = '0;
    reg_waddr_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i && start_i) begin
          state_d = (div_by_zero || overflow) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (count_q == LAST_COUNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        busy_o  = 1'b1;
        state_d = flush_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          ready_o     = 1'b1;
          reg_we_o    = WRITE_ENABLE;
          result_o    = result_q;
          reg_waddr_o = rd_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers. Special cases write their final result straight
  // into result_q at start; the normal path fills it during FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q     <= '0;
      divisor_q      <= '0;
      quot_q         <= '0;
      rem_q          <= '0;
      result_q       <= '0;
      count_q        <= '0;
      op_q           <= '0;
      rd_q           <= '0;
      signs_differ_q <= 1'b0;
      dividend_neg_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            op_q           <= op_i;
            rd_q           <= reg_waddr_i;
            dividend_q     <= dividend_abs;
            divisor_q      <= divisor_abs;
            signs_differ_q <= dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1];
            dividend_neg_q <= dividend_i[DATA_WIDTH-1];
            quot_q         <= '0;
            rem_q          <= '0;
            count_q        <= '0;
            if (div_by_zero) begin
              result_q <= op_i[1] ? dividend_i : '1;
            end else if (overflow) begin
              result_q <= op_i[1] ? '0 : MIN_NEG;
            end
          end
        end
        ST_CALC: begin
          rem_q   <= rem_step;
          quot_q  <= {quot_q[DATA_WIDTH-2:0], q_bit};
          count_q <= count_q + 1'b1;
        end
        ST_FIX: begin
          result_q <= op_q[1] ? rem_fix : quot_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl
//   Scoreboard bench for ex_div_ctrl: stimulus pushes expected writebacks,
//   a monitor process pops and compares whenever ready_o is seen.
module tb_ex_div_ctrl;

  localparam int LAT_NORMAL  = 33;
  localparam int LAT_SPECIAL = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int          ready_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   cyc;

  ex_div_ctrl #(
    .DATA_WIDTH  (32),
    .RADDR_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to check result latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Generic comparison with failure reporting.
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor sample, taken on the falling edge away from the active edge.
  task automatic monitor_sample();
    exp_t e;
    if (rst_n) begin
      check_output("we_equals_ready", {31'd0, reg_we_o}, {31'd0, ready_o});
      if (ready_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready actual result=0x%08h rd=%0d expected no writeback",
                   result_o, reg_waddr_o);
        end else begin
          e = sb_q.pop_front();
          check_output("result", result_o, e.result);
          check_output("reg_waddr", {27'd0, reg_waddr_o}, {27'd0, e.rd});
          check_output("latency_cycle", cyc, e.ready_cyc);
        end
      end else begin
        check_output("idle_result_zero", result_o, 32'd0);
        check_output("idle_waddr_zero", {27'd0, reg_waddr_o}, 32'd0);
      end
    end
  endtask

  // Issue one start pulse; optionally record the expected writeback.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] exp_res,
                                input int lat, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    if (push) begin
      e.result    = exp_res;
      e.rd        = rd;
      e.ready_cyc = cyc + 1 + lat;
      sb_q.push_back(e);
    end
    start_i     = 1'b1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = rd;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Wait for the scoreboard to drain and the DUT to go quiet, bounded.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy_o || ready_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL wait_idle actual pending=%0d busy=%0b expected drained", sb_q.size(), busy_o);
    end
  endtask

  // Stimulus sequence, with the monitor forked alongside it.
  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    op_i        = 2'b00;
    dividend_i  = '0;
    divisor_i   = '0;
    reg_waddr_i = '0;
    flush_i     = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitor_sample();
      end
    join_none

    #2;
    $display("[TB] reset state");
    check_output("rst_busy", {31'd0, busy_o}, 32'd0);
    check_output("rst_ready", {31'd0, ready_o}, 32'd0);
    check_output("rst_we", {31'd0, reg_we_o}, 32'd0);
    check_output("rst_result", result_o, 32'd0);
    check_output("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] normal divides");
    apply_stimulus(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, LAT_NORMAL, 1'b1);
    check_output("busy_after_start", {31'd0, busy_o}, 32'd1);
    wait_idle();
    apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, LAT_NORMAL, 1'b1);
    wait_idle();
    apply_stimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, LAT_NORMAL, 1'b1);
    wait_idle();
    apply_stimulus(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, LAT_NORMAL, 1'b1);
    wait_idle();
    apply_stimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, LAT_NORMAL, 1'b1);
    wait_idle();
    apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 5'd10, 32'd1, LAT_NORMAL, 1'b1);
    wait_idle();
    apply_stimulus(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 32'h7FFF_FFFF, LAT_NORMAL, 1'b1);
    wait_idle();

    $display("[TB] special cases");
    apply_stimulus(2'b00, 32'd123, 32'd0, 5'd11, 32'hFFFF_FFFF, LAT_SPECIAL, 1'b1);
    check_output("dz_div_busy", {31'd0, busy_o}, 32'd0);
    wait_idle();
    apply_stimulus(2'b11, 32'd123, 32'd0, 5'd12, 32'd123, LAT_SPECIAL, 1'b1);
    check_output("dz_remu_busy", {31'd0, busy_o}, 32'd0);
    wait_idle();
    apply_stimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, LAT_SPECIAL, 1'b1);
    check_output("ovf_div_busy", {31'd0, busy_o}, 32'd0);
    wait_idle();
    apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, LAT_SPECIAL, 1'b1);
    wait_idle();

    $display("[TB] flush mid-calc");
    apply_stimulus(2'b01, 32'd1000, 32'd3, 5'd15, 32'd0, LAT_NORMAL, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check_output("flush_busy_drop", {31'd0, busy_o}, 32'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    apply_stimulus(2'b01, 32'd9, 32'd3, 5'd16, 32'd3, LAT_NORMAL, 1'b1);
    wait_idle();

    $display("[TB] flush in done and flush with start");
    apply_stimulus(2'b01, 32'd5, 32'd0, 5'd17, 32'd0, LAT_SPECIAL, 1'b0);
    flush_i = 1'b1;
    #1;
    check_output("done_flush_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    start_i = 1'b1;
    op_i    = 2'b01;
    dividend_i = 32'd40;
    divisor_i  = 32'd4;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    check_output("idle_flush_start_busy", {31'd0, busy_o}, 32'd0);
    check_output("idle_flush_start_ready", {31'd0, ready_o}, 32'd0);

    $display("[TB] restart ignored while busy");
    apply_stimulus(2'b01, 32'd50, 32'd5, 5'd18, 32'd10, LAT_NORMAL, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start_i    = 1'b1;
    dividend_i = 32'd77;
    divisor_i  = 32'd7;
    reg_waddr_i = 5'd19;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check_output("restart_busy", {31'd0, busy_o}, 32'd1);
    wait_idle();

    $display("[TB] reset mid-calc");
    apply_stimulus(2'b01, 32'd1000, 32'd3, 5'd20, 32'd0, LAT_NORMAL, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", {31'd0, busy_o}, 32'd0);
    check_output("midrst_ready", {31'd0, ready_o}, 32'd0);
    check_output("midrst_we", {31'd0, reg_we_o}, 32'd0);
    check_output("midrst_result", result_o, 32'd0);
    check_output("midrst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    check_output("postrst_busy", {31'd0, busy_o}, 32'd0);

    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
